// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU codes, FSM
// state encodings and the divide-by-zero quotient constant.
package muldiv_sequencer_pkg;

    localparam logic [4:0] ALU_mult = 5'd24;
    localparam logic [4:0] ALU_div  = 5'd25;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One ITER_BITS-wide iteration of the unsigned datapath: right-shifting
// shift-add multiply or left-shifting restoring divide on {acc_hi, acc_lo}.
module muldiv_step #(
    parameter int ITER_BITS = 1
) (
    input  logic        is_div,
    input  logic [31:0] operand,
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    output logic [31:0] next_hi,
    output logic [31:0] next_lo
);

    logic [32:0] t;
    logic [31:0] h;
    logic [31:0] l;

    // mult: acc_lo holds the unretired multiplier bits, acc_hi the partial sum.
    // div:  acc_lo holds the dividend shifting out / quotient shifting in, acc_hi the remainder.
    always_comb begin
        t = '0;
        h = acc_hi;
        l = acc_lo;
        for (int i = 0; i < ITER_BITS; i++) begin
            if (is_div) begin
                t = {h, l[31]};
                l = {l[30:0], 1'b0};
                if (t >= {1'b0, operand}) begin
                    t    = t - {1'b0, operand};
                    l[0] = 1'b1;
                end
                h = t[31:0];
            end else begin
                t = l[0] ? ({1'b0, h} + {1'b0, operand}) : {1'b0, h};
                h = t[32:1];
                l = {t[0], l[31:1]};
            end
        end
        next_hi = h;
        next_lo = l;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide unit owning HI/LO. Works on magnitudes
// and applies sign correction when the result is written back in DONE.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int ITER_BITS = 1   // legal: 1, 2, 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int ITERS = 32 / ITER_BITS;
    localparam int CW    = 6;

    md_state_t   state;
    logic [CW-1:0] count;
    logic        is_div;
    logic        div0;
    logic        sign_q;
    logic        sign_r;
    logic [31:0] operand;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic        valid_op;
    logic        issue;
    logic [63:0] prod_mag;
    logic [63:0] prod_fix;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign valid_op = (op == ALU_mult) || (op == ALU_div);
    assign issue    = start && valid_op && !flush;
    assign stall    = busy | issue;

    muldiv_step #(.ITER_BITS(ITER_BITS)) u_step (
        .is_div  (is_div),
        .operand (operand),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_comb begin
        prod_mag = {acc_hi, acc_lo};
        prod_fix = sign_q ? (~prod_mag + 64'd1) : prod_mag;
        q_fix    = sign_q ? (~acc_lo + 32'd1) : acc_lo;
        r_fix    = sign_r ? (~acc_hi + 32'd1) : acc_hi;
    end

    // busy covers BUSY and DONE so the issuer stays stalled until write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MD_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            is_div  <= 1'b0;
            div0    <= 1'b0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            operand <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (issue) begin
                        is_div <= (op == ALU_div);
                        sign_q <= src_a[31] ^ src_b[31];
                        sign_r <= src_a[31];
                        count  <= CW'(ITERS);
                        busy   <= 1'b1;
                        acc_hi <= '0;
                        div0   <= 1'b0;
                        state  <= MD_BUSY;
                        if (op == ALU_div) begin
                            operand <= abs32(src_b);
                            acc_lo  <= abs32(src_a);
                            // Divide by zero: remainder path rebuilds src_a from its magnitude.
                            if (src_b == 32'd0) begin
                                div0   <= 1'b1;
                                acc_hi <= abs32(src_a);
                                state  <= MD_DONE;
                            end
                        end else begin
                            operand <= abs32(src_a);
                            acc_lo  <= abs32(src_b);
                        end
                    end
                end
                MD_BUSY: begin
                    if (flush) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count - CW'(1);
                        if (count == CW'(1))
                            state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        if (div0) begin
                            hi <= r_fix;
                            lo <= MD_DIV0_LO;
                        end else if (is_div) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
